// File: rtl/edge_gen_if.sv
// edge_gen_if: control, configuration and waveform/status signals of the pulse-train generator.
interface edge_gen_if #(
    parameter int CNT_W = 16,
    parameter int NUM_W = 16
);
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] cfg_high;
    logic [CNT_W-1:0] cfg_low;
    logic [NUM_W-1:0] cfg_num;
    logic             data_out;
    logic             pos_edge;
    logic             neg_edge;
    logic             busy;
    logic             done;
    logic [NUM_W-1:0] pulse_cnt;

    modport master (
        output start, stop, cfg_high, cfg_low, cfg_num,
        input  data_out, pos_edge, neg_edge, busy, done, pulse_cnt
    );

    modport slave (
        input  start, stop, cfg_high, cfg_low, cfg_num,
        output data_out, pos_edge, neg_edge, busy, done, pulse_cnt
    );
endinterface

// File: rtl/edge_gen.sv
// edge_gen: programmable pulse-train generator with registered edge strobes.
// Optional EDGE_GEN_OUT_INV_EN inverts data_out (idle 1) and swaps the strobes to follow it.
module edge_gen #(
    parameter int CNT_W = 16,
    parameter int NUM_W = 16
) (
    input logic       clk,
    input logic       rst_n,
    edge_gen_if.slave bus
);
`ifdef EDGE_GEN_OUT_INV_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, high_q, high_d, low_q, low_d;
    logic [NUM_W-1:0] num_q, num_d, pulse_cnt_q, pulse_cnt_d;
    logic             data_out_q, data_out_d, pos_edge_q, pos_edge_d, neg_edge_q, neg_edge_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             rise, fall, last;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        high_d      = high_q;
        low_d       = low_q;
        num_d       = num_q;
        pulse_cnt_d = pulse_cnt_q;
        rise        = 1'b0;
        fall        = 1'b0;
        done_d      = 1'b0;
        last        = (num_q != '0) && (pulse_cnt_q == num_q);
        // cnt holds the cycles remaining in the current phase after this one
        case (state_q)
            IDLE: if (bus.start && !bus.stop) begin
                high_d      = (bus.cfg_high == '0) ? CNT_W'(1) : bus.cfg_high;
                low_d       = (bus.cfg_low == '0) ? CNT_W'(1) : bus.cfg_low;
                num_d       = bus.cfg_num;
                pulse_cnt_d = '0;
                cnt_d       = high_d - 1'b1;
                state_d     = HIGH;
                rise        = 1'b1;
            end
            HIGH: if (bus.stop || cnt_q == '0) begin
                fall        = 1'b1;
                pulse_cnt_d = pulse_cnt_q + 1'b1;
                state_d     = bus.stop ? IDLE : LOW;
                done_d      = bus.stop;
                cnt_d       = bus.stop ? '0 : low_q - 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            LOW: if (bus.stop || (cnt_q == '0 && last)) begin
                state_d = IDLE;
                done_d  = 1'b1;
                cnt_d   = '0;
            end else if (cnt_q == '0) begin
                state_d = HIGH;
                rise    = 1'b1;
                cnt_d   = high_q - 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
        busy_d     = state_d != IDLE;
        data_out_d = INV ^ (state_d == HIGH);
        pos_edge_d = INV ? fall : rise;
        neg_edge_d = INV ? rise : fall;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            high_q      <= '0;
            low_q       <= '0;
            num_q       <= '0;
            pulse_cnt_q <= '0;
            data_out_q  <= INV;
            pos_edge_q  <= 1'b0;
            neg_edge_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            high_q      <= high_d;
            low_q       <= low_d;
            num_q       <= num_d;
            pulse_cnt_q <= pulse_cnt_d;
            data_out_q  <= data_out_d;
            pos_edge_q  <= pos_edge_d;
            neg_edge_q  <= neg_edge_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.pos_edge  = pos_edge_q;
    assign bus.neg_edge  = neg_edge_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pulse_cnt = pulse_cnt_q;
endmodule

// File: tb/tb_edge_gen.sv
// tb_edge_gen: directed checks of edge_gen waveforms, strobes, counts, stop and reset behaviour.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_edge_gen;
`ifdef EDGE_GEN_OUT_INV_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errs = 0;
    int   checks = 0;

    edge_gen_if #(.CNT_W(16), .NUM_W(16)) bus ();

    edge_gen #(.CNT_W(16), .NUM_W(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // act is the logical active level; strobes are named by logical rise/fall
    task automatic expect_out(input string tag, input int act, input int r, input int f,
                              input int b, input int d, input int pc);
        logic [4:0] obs, exp;
        obs = {bus.data_out, bus.pos_edge, bus.neg_edge, bus.busy, bus.done};
        exp = {INV ^ act[0], INV ? f[0] : r[0], INV ? r[0] : f[0], b[0], d[0]};
        check({tag, " out"}, 32'(obs), 32'(exp));
        check({tag, " cnt"}, 32'(bus.pulse_cnt), 32'(pc));
    endtask

    task automatic start_run(input int h, input int l, input int n);
        bus.start = 1'b1;
        bus.cfg_high = 16'(h);
        bus.cfg_low = 16'(l);
        bus.cfg_num = 16'(n);
        tick();
        bus.start = 1'b0;
    endtask

    int a2[11] = '{1, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0};
    int r2[11] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    int f2[11] = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
    int p2[11] = '{0, 0, 0, 1, 1, 1, 1, 1, 2, 2, 2};
    int a3[7] = '{1, 0, 1, 0, 1, 0, 0};
    int p3[7] = '{0, 1, 1, 2, 2, 3, 3};

    initial begin
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.cfg_high = '0;
        bus.cfg_low = '0;
        bus.cfg_num = '0;
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) expect_out($sformatf("idle%0d", i), 0, 0, 0, 0, 0, 0);

        // 3/2 x2, with an ignored start carrying other config during the run
        start_run(3, 2, 2);
        for (int i = 0; i < 11; i++) begin
            expect_out($sformatf("run32 c%0d", i + 1), a2[i], r2[i], f2[i], i < 10, i == 10, p2[i]);
            bus.start = (i == 1);
            bus.cfg_high = (i == 1) ? 16'd7 : 16'd3;
            bus.cfg_num = (i == 1) ? 16'd0 : 16'd2;
            tick();
        end
        expect_out("run32 after", 0, 0, 0, 0, 0, 2);

        // zero config clamps to 1/1, then restart in the done cycle
        start_run(0, 0, 3);
        for (int i = 0; i < 7; i++) begin
            expect_out($sformatf("clamp c%0d", i + 1), a3[i], a3[i] && i < 6, !a3[i] && i < 6, i < 6, i == 6, p3[i]);
            if (i < 6) tick();
        end
        start_run(1, 1, 1);
        expect_out("restart c1", 1, 1, 0, 1, 0, 0);
        tick();
        expect_out("restart c2", 0, 0, 1, 1, 0, 1);
        tick();
        expect_out("restart c3", 0, 0, 0, 0, 1, 1);

        // continuous 4/4, stop in 2nd high cycle of pulse 5 (cycle 34)
        start_run(4, 4, 0);
        for (int i = 1; i < 34; i++) tick();
        expect_out("cont c34", 1, 0, 0, 1, 0, 4);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        expect_out("stop high", 0, 0, 1, 0, 1, 5);
        tick();
        expect_out("stop high idle", 0, 0, 0, 0, 0, 5);

        // stop during a low phase: no strobes
        start_run(2, 2, 0);
        tick();
        tick();
        expect_out("low c3", 0, 0, 1, 1, 0, 1);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        expect_out("stop low", 0, 0, 0, 0, 1, 1);

        // start and stop together in IDLE: nothing starts
        bus.start = 1'b1;
        bus.stop = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop = 1'b0;
        expect_out("start+stop", 0, 0, 0, 0, 0, 1);
        tick();
        expect_out("start+stop 2", 0, 0, 0, 0, 0, 1);

        // reset mid-HIGH
        start_run(5, 5, 0);
        tick();
        expect_out("pre reset", 1, 0, 0, 1, 0, 0);
        rst_n = 1'b0;
        tick();
        expect_out("reset mid", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();
        expect_out("reset after", 0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/edge_gen.md
Name: edge_gen

Overview:
- Programmable pulse-train generator. It is the transmit-side counterpart of the codebase's edge detection: instead of sampling a line and reporting edges, it drives a line with timed edges.
- Used to produce test stimulus and gating waveforms inside the spectrum analyzer datapath.
- Emits registered one-cycle pos_edge/neg_edge strobes aligned with its own output transitions, so downstream logic needs no separate edge detection.

Parameters:
- CNT_W, 16, width of the high-time and low-time counters (cycles).
- NUM_W, 16, width of the pulse-count register.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- start  input  1  one-cycle request; accepted only in IDLE.
- stop  input  1  abort request; effective in any non-IDLE state.
- cfg_high  input  CNT_W  high-phase length in cycles; latched on accepted start.
- cfg_low  input  CNT_W  low-phase length in cycles; latched on accepted start.
- cfg_num  input  NUM_W  number of pulses; 0 = continuous until stop.
- data_out  output  1  generated waveform, registered.
- pos_edge  output  1  one-cycle strobe, high in the first cycle data_out is 1.
- neg_edge  output  1  one-cycle strobe, high in the first cycle data_out returns to 0.
- busy  output  1  high in HIGH and LOW states.
- done  output  1  one-cycle strobe when a run ends (completed or aborted).
- pulse_cnt  output  NUM_W  pulses completed in the current/last run; cleared on accepted start.

Behaviour:
- Reset (rst_n=0 at a rising edge): state IDLE; data_out, pos_edge, neg_edge, busy, done = 0; pulse_cnt = 0; internal counters = 0. Reset mid-run aborts immediately. No done or neg_edge is produced by reset.
- States: IDLE, HIGH, LOW. All outputs are registered.
- IDLE: start=1 and stop=0 latches cfg_*. A zero cfg_high or cfg_low is clamped to 1. Next cycle: state HIGH, data_out=1, pos_edge=1, busy=1, pulse_cnt=0.
- Latency: start sampled at edge N gives data_out=1 from edge N+1.
- HIGH: data_out stays 1 for exactly H cycles (H = latched high time), then LOW with data_out=0 and neg_edge=1. pulse_cnt increments in that same cycle.
- LOW: data_out stays 0 for exactly L cycles, then:
  - If cfg_num≠0 and pulse_cnt==cfg_num: go to IDLE, busy=0, done=1 (one cycle).
  - Otherwise: go to HIGH with pos_edge=1.
- Period is H+L cycles. There is no extra idle cycle between pulses.
- Continuous mode (cfg_num=0): runs until stop. pulse_cnt wraps modulo 2^NUM_W.
- stop in HIGH: next cycle data_out=0, neg_edge=1, pulse_cnt increments (partial pulse counts), done=1, state IDLE.
- stop in LOW: next cycle state IDLE, done=1, no edge strobes.
- start while busy is ignored. Config inputs are don't-care except on an accepted start.
- start and stop in the same cycle in IDLE: stop wins and nothing starts. Outside IDLE, stop in IDLE is ignored.
- done and a new accepted start: start is accepted in the cycle after done (state is IDLE then).
- pos_edge and neg_edge are never both 1 in the same cycle.

Optional Feature:
- Macro EDGE_GEN_OUT_INV_EN.
- Defined: data_out is inverted (idle level 1, active phase 0, reset value 1). pos_edge marks the return to 1 and neg_edge marks entry to the active phase, so the strobes always describe the physical data_out transitions.
- Not defined: behaviour exactly as above with idle level 0.

Test Plan:
- Reset then idle 10 cycles -> data_out=0, busy=0, done=0, no strobes, pulse_cnt=0.
- start with cfg_high=3, cfg_low=2, cfg_num=2 -> data_out pattern 1,1,1,0,0,1,1,1,0,0. pos_edge at cycles 1 and 6, neg_edge at 4 and 9, done one cycle after the final low phase, pulse_cnt=2, busy low with done.
- start with cfg_high=0, cfg_low=0, cfg_num=3 -> clamped to 1/1: alternating 1,0 three times, done once, pulse_cnt=3.
- cfg_num=0, cfg_high=4, cfg_low=4, stop asserted in the 2nd high cycle of pulse 5 -> next cycle data_out=0, neg_edge=1, done=1, pulse_cnt=5, IDLE.
- During a run, pulse start again with different cfg, and assert start+stop together in IDLE -> run unaffected and nothing starts, respectively.
- Assert rst_n=0 mid-HIGH -> next edge data_out=0, busy=0, no done, no neg_edge. Repeat with EDGE_GEN_OUT_INV_EN defined and confirm the inverted levels and swapped strobes.
